// File: rtl/text_frame_buf.sv
// Double-buffered character RAM: the filler writes the back bank while the renderer reads the front.
// Banks swap on vsync once the back frame is complete and the hold time has elapsed.
module text_frame_buf #(
    parameter int width       = 128,
    parameter int height      = 48,
    parameter int char_width  = 8,
    parameter int blank_char  = 32,
    parameter int hold_frames = 60,
    localparam int XW  = (width > 1) ? $clog2(width) : 1,
    localparam int YW  = (height > 1) ? $clog2(height) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [XW-1:0]         wr_x,
    input  logic [YW-1:0]         wr_y,
    input  logic [char_width-1:0] wr_c,
    output logic                  refresh,
    output logic                  zero_buf,
    input  logic                  clear,
    input  logic                  vsync,
    input  logic [XW-1:0]         rd_x,
    input  logic [YW-1:0]         rd_y,
    output logic [char_width-1:0] rd_c,
    output logic                  front_bank,
    output logic                  frame_valid,
    output logic                  busy
);

    localparam int DEPTH = width * height;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HCW   = (hold_frames > 1) ? $clog2(hold_frames) : 1;

    localparam logic [XW:0]             X_LIM    = (XW + 1)'(width);
    localparam logic [YW:0]             Y_LIM    = (YW + 1)'(height);
    localparam logic [XW-1:0]           X_LAST   = XW'(width - 1);
    localparam logic [YW-1:0]           Y_LAST   = YW'(height - 1);
    localparam logic [HCW-1:0]          HOLD_MAX = HCW'(hold_frames - 1);
    localparam logic [char_width-1:0]   BLANK    = char_width'(blank_char);

    typedef enum logic [1:0] {
        ST_START,
        ST_FILL,
        ST_WAIT
    } state_t;

    state_t         state_q, state_d;
    logic           first_q, first_d;
    logic           zero_buf_q, zero_buf_d;
    logic           clear_pend_q, clear_pend_d;
    logic           front_q, front_d;
    logic           valid_q, valid_d;
    logic [HCW-1:0] hold_q, hold_d;

    logic           fill_first;
    logic           wr_ok;
    logic           last_wr;
    logic           swap;
    logic           wr_in_range;
    logic           rd_in_range;
    logic [AW-1:0]  wr_addr;
    logic [AW-1:0]  rd_addr;

    assign wr_in_range = ({1'b0, wr_x} < X_LIM) && ({1'b0, wr_y} < Y_LIM);
    assign rd_in_range = ({1'b0, rd_x} < X_LIM) && ({1'b0, rd_y} < Y_LIM);
    assign wr_addr     = AW'(wr_y) * AW'(width) + AW'(wr_x);
    assign rd_addr     = AW'(rd_y) * AW'(width) + AW'(rd_x);

    assign fill_first  = (state_q == ST_FILL) && first_q;
    assign wr_ok       = (state_q == ST_FILL) && !first_q && wr_en && wr_in_range;
    assign last_wr     = wr_ok && (wr_x == X_LAST) && (wr_y == Y_LAST);
    assign swap        = (state_q == ST_WAIT) && vsync && (hold_q == HOLD_MAX);

    always_comb begin
        state_d      = state_q;
        first_d      = first_q;
        zero_buf_d   = zero_buf_q;
        clear_pend_d = clear_pend_q;
        front_d      = front_q;
        valid_d      = valid_q;
        hold_d       = hold_q;

        case (state_q)
            ST_START: begin
                state_d = ST_FILL;
                first_d = 1'b1;
            end
            ST_FILL: begin
                first_d = 1'b0;
                if (fill_first) begin
                    zero_buf_d   = clear_pend_q;
                    clear_pend_d = 1'b0;
                end
                if (last_wr) begin
                    state_d    = ST_WAIT;
                    zero_buf_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (swap) begin
                    state_d = ST_FILL;
                    first_d = 1'b1;
                    front_d = ~front_q;
                    valid_d = 1'b1;
                end
            end
            default: state_d = ST_START;
        endcase

        // A clear seen during the first fill cycle must survive to the next fill.
        if (clear) begin
            clear_pend_d = 1'b1;
        end

        if (swap) begin
            hold_d = '0;
        end else if (vsync && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + HCW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_START;
            first_q      <= 1'b0;
            zero_buf_q   <= 1'b0;
            clear_pend_q <= 1'b0;
            front_q      <= 1'b0;
            valid_q      <= 1'b0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            first_q      <= first_d;
            zero_buf_q   <= zero_buf_d;
            clear_pend_q <= clear_pend_d;
            front_q      <= front_d;
            valid_q      <= valid_d;
            hold_q       <= hold_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            localparam logic BANK_ID = 1'(gi);
            logic [char_width-1:0] mem [DEPTH];
            logic [char_width-1:0] rd_data_q;

            always_ff @(posedge clk) begin
                if (wr_ok && (front_q != BANK_ID)) begin
                    mem[wr_addr] <= wr_c;
                end
                rd_data_q <= mem[rd_addr];
            end
        end
    endgenerate

    // The blank/bank selection is kept apart from the RAM read so reset blanks the display at once.
    logic rd_sel_q;
    logic rd_bank_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_sel_q  <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            rd_sel_q  <= valid_q && rd_in_range;
            rd_bank_q <= front_q;
        end
    end

    assign rd_c        = !rd_sel_q ? BLANK :
                         (rd_bank_q ? g_bank[1].rd_data_q : g_bank[0].rd_data_q);
    assign refresh     = fill_first;
    assign zero_buf    = zero_buf_q;
    assign front_bank  = front_q;
    assign frame_valid = valid_q;
    assign busy        = (state_q == ST_FILL);

endmodule

// File: tb/tb_text_frame_buf.sv
// Directed bench for text_frame_buf: a frame-level model checked every cycle plus literal spot checks.
module tb_text_frame_buf;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int HF = 2;
    localparam int BL = 32;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_en;
    logic [1:0] wr_x;
    logic [0:0] wr_y;
    logic [7:0] wr_c;
    logic       refresh;
    logic       zero_buf;
    logic       clear;
    logic       vsync;
    logic [1:0] rd_x;
    logic [0:0] rd_y;
    logic [7:0] rd_c;
    logic       front_bank;
    logic       frame_valid;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    bit run_cmp  = 1'b0;

    text_frame_buf #(
        .width(W), .height(H), .char_width(8), .blank_char(BL), .hold_frames(HF)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_c(wr_c),
        .refresh(refresh), .zero_buf(zero_buf), .clear(clear), .vsync(vsync),
        .rd_x(rd_x), .rd_y(rd_y), .rd_c(rd_c),
        .front_bank(front_bank), .frame_valid(frame_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase 0 = awaiting start, 1 = filling, 2 = frame complete awaiting swap.
    int       m_phase;
    bit       m_first, m_zb, m_cp, m_fb, m_fv;
    int       m_hold;
    logic [7:0] m_rd;
    logic [7:0] m_mem [2][W*H];

    wire p_first = (m_phase == 1) && m_first;
    wire p_acc   = (m_phase == 1) && !m_first && wr_en && (int'(wr_x) < W) && (int'(wr_y) < H);
    wire p_last  = p_acc && (int'(wr_x) == W - 1) && (int'(wr_y) == H - 1);
    wire p_swap  = (m_phase == 2) && vsync && (m_hold == HF - 1);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase <= 0; m_first <= 1'b0; m_zb <= 1'b0; m_cp <= 1'b0;
            m_fb <= 1'b0; m_fv <= 1'b0; m_hold <= 0; m_rd <= 8'(BL);
        end else begin
            m_rd <= (m_fv && int'(rd_x) < W && int'(rd_y) < H) ?
                    m_mem[m_fb][int'(rd_y) * W + int'(rd_x)] : 8'(BL);
            if (p_acc) m_mem[!m_fb][int'(wr_y) * W + int'(wr_x)] <= wr_c;
            if (m_phase == 0) begin
                m_phase <= 1; m_first <= 1'b1;
            end else if (m_phase == 1) begin
                m_first <= 1'b0;
                if (p_last) m_phase <= 2;
            end else if (p_swap) begin
                m_phase <= 1; m_first <= 1'b1; m_fb <= !m_fb; m_fv <= 1'b1;
            end
            if (p_first) m_zb <= m_cp;
            else if (p_last) m_zb <= 1'b0;
            if (clear) m_cp <= 1'b1;
            else if (p_first) m_cp <= 1'b0;
            if (p_swap) m_hold <= 0;
            else if (vsync && m_hold < HF - 1) m_hold <= m_hold + 1;
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("cyc_refresh", 32'(refresh), 32'((m_phase == 1) && m_first));
            chk("cyc_busy", 32'(busy), 32'(m_phase == 1));
            chk("cyc_zero_buf", 32'(zero_buf), 32'(m_zb));
            chk("cyc_front_bank", 32'(front_bank), 32'(m_fb));
            chk("cyc_frame_valid", 32'(frame_valid), 32'(m_fv));
            chk("cyc_rd_c", 32'(rd_c), 32'(m_rd));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int x, input int y, input logic [7:0] c);
        wr_en = 1'b1; wr_x = 2'(x); wr_y = 1'(y); wr_c = c;
        tick();
        wr_en = 1'b0; vsync = 1'b0; clear = 1'b0;
    endtask

    task automatic pulse_vsync();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
    endtask

    initial begin
        int n;
        reset_n = 1'b0; wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_c = '0;
        clear = 1'b0; vsync = 1'b0; rd_x = 2'd2; rd_y = 1'd1;
        repeat (2) @(posedge clk);
        run_cmp = 1'b1;
        #3 reset_n = 1'b1;
        #1;
        chk("rst_refresh", 32'(refresh), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_front", 32'(front_bank), 0);
        chk("rst_valid", 32'(frame_valid), 0);
        chk("rst_rd_c", 32'(rd_c), BL);

        // Cycle 2 after release: first fill cycle carries the refresh pulse.
        tick();
        chk("refresh_cycle2", 32'(refresh), 1);
        chk("fill1_busy", 32'(busy), 1);
        chk("fill1_zero_buf", 32'(zero_buf), 0);
        tick();
        chk("refresh_one_cycle", 32'(refresh), 0);
        for (int i = 0; i < 8; i++) do_write(i % 4, i / 4, 8'(65 + i));
        chk("fill1_done_busy", 32'(busy), 0);

        pulse_vsync();
        chk("vs1_front", 32'(front_bank), 0);
        chk("vs1_valid", 32'(frame_valid), 0);
        pulse_vsync();
        chk("vs2_front", 32'(front_bank), 1);
        chk("vs2_valid", 32'(frame_valid), 1);
        chk("swap_edge_rd_blank", 32'(rd_c), BL);
        chk("swap_refresh", 32'(refresh), 1);
        // A last-address write during the refresh cycle must be ignored.
        wr_en = 1'b1; wr_x = 2'd3; wr_y = 1'd1; wr_c = 8'h5A;
        tick();
        wr_en = 1'b0;
        chk("read_G", 32'(rd_c), 32'h47);
        chk("refresh_wr_ignored", 32'(busy), 1);

        for (int i = 0; i < 8; i++) begin
            clear = (i == 2);
            do_write(i % 4, i / 4, 8'(97 + i));
        end
        chk("fill2_done_busy", 32'(busy), 0);
        do_write(1, 0, 8'h51);
        do_write(3, 1, 8'h52);
        chk("wait_wr_ignored", 32'(busy), 0);
        pulse_vsync();
        pulse_vsync();
        chk("swap2_front", 32'(front_bank), 0);
        tick();
        chk("read_g", 32'(rd_c), 32'h67);
        chk("fill3_zero_buf", 32'(zero_buf), 1);
        rd_x = 2'd1; rd_y = 1'd0;
        tick();
        chk("read_b_after_wait_wr", 32'(rd_c), 32'h62);
        rd_x = 2'd3; rd_y = 1'd1;
        tick();
        chk("read_h_after_wait_wr", 32'(rd_c), 32'h68);

        // Saturate hold during the fill, then land a vsync on the last write.
        for (int i = 0; i < 8; i++) begin
            vsync = (i == 1 || i == 3 || i == 7);
            do_write(i % 4, i / 4, 8'(BL));
        end
        chk("coincide_no_swap", 32'(front_bank), 0);
        chk("coincide_busy", 32'(busy), 0);
        chk("coincide_zero_buf", 32'(zero_buf), 0);
        pulse_vsync();
        chk("swap3_front", 32'(front_bank), 1);
        tick();
        for (int i = 0; i < 8; i++) begin
            rd_x = 2'(i % 4); rd_y = 1'(i / 4);
            tick();
            chk("blank_frame_rd", 32'(rd_c), BL);
        end
        chk("fill4_zero_buf", 32'(zero_buf), 0);

        for (int i = 0; i < 3; i++) do_write(i, 0, 8'(120 + i));
        #2 reset_n = 1'b0;
        #1;
        chk("async_rd_c", 32'(rd_c), BL);
        chk("async_front", 32'(front_bank), 0);
        chk("async_valid", 32'(frame_valid), 0);
        chk("async_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        #1;
        n = 0;
        while (!refresh && n < 6) begin
            tick();
            n++;
        end
        chk("rerefresh_latency", 32'(n), 1);
        repeat (3) tick();

        run_cmp = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/text_frame_buf.md
Name: text_frame_buf

Overview:
- Double-buffered character RAM between the random-text filler (upstream) and the XGA text renderer (downstream).
- The filler writes a complete frame into the back bank while the renderer reads the front bank.
- Banks swap only at a vsync boundary, and only once the back frame is complete and a minimum hold time has elapsed.
- The block drives the filler's refresh and zero_buf inputs, so it also sequences when new frames are generated.

Parameters:
- width, 128, characters per row
- height, 48, character rows
- char_width, 8, bits per character code
- blank_char, 32, code returned while no frame has been displayed and written when clearing
- hold_frames, 60, minimum vsyncs between swaps (>=1)

Ports:
- clk  in  1  system clock, all logic on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe from the filler
- wr_x  in  log2(width)  write column
- wr_y  in  log2(height)  write row
- wr_c  in  char_width  write character
- refresh  out  1  one-cycle pulse that restarts the filler at (0,0)
- zero_buf  out  1  level; when high, the filler emits blank_char for the whole fill
- clear  in  1  pulse; the next fill is a blank fill
- vsync  in  1  one-cycle frame-boundary pulse from video timing
- rd_x  in  log2(width)  renderer read column
- rd_y  in  log2(height)  renderer read row
- rd_c  out  char_width  character at (rd_x,rd_y) of the front bank
- front_bank  out  1  index of the bank being displayed
- frame_valid  out  1  high once the first swap has occurred
- busy  out  1  high while in state FILL

Behaviour:
- Storage: two banks, each width*height entries of char_width bits, addr = y*width + x. No reset of RAM contents.
- Reset values: state=START, refresh=0, zero_buf=0, rd_c=blank_char, front_bank=0, frame_valid=0, busy=0, hold counter=0, clear_pending=0.
- The back bank is always ~front_bank.
- START: advance to FILL after 1 cycle.
- FILL:
  - refresh=1 in the first FILL cycle only. zero_buf is latched from clear_pending in that same cycle, and clear_pending clears there.
  - Writes are accepted when wr_en=1, it is not the first FILL cycle, wr_x<width and wr_y<height. Accepted writes go to the back bank.
  - An accepted write at (width-1, height-1) transitions to WAIT on the next edge; zero_buf drops to 0 on that edge.
- WAIT:
  - wr_en is ignored.
  - On vsync with hold==hold_frames-1, take the swap. On that edge: front_bank toggles, frame_valid=1, hold=0, state becomes FILL and the refresh pulse follows.
- Hold counter: increments on every vsync (any state), saturating at hold_frames-1, and resets on a swap.
- A vsync while in FILL never swaps. The swap waits for the first qualifying vsync once in WAIT.
- A last write and a vsync on the same edge: state goes to WAIT and no swap is taken; the counter still counts that vsync.
- clear sets clear_pending in any state. A clear arriving in the first FILL cycle applies to the next fill, not the current one.
- Read path:
  - Latency is 1 cycle: rd_c <= frame_valid ? front[rd_y*width+rd_x] : blank_char.
  - The read uses the front_bank value before the edge, so a swap on the same edge does not affect that read.
  - Out-of-range read addresses return blank_char.
- Reset mid-fill: everything returns to reset values, the display shows blank_char, and the fill restarts via START.
- Width handling: address product computed at log2(width*height) bits; hold counter is log2(hold_frames) bits, minimum 1.

Test Plan:
Bench parameters: width=4, height=2, hold_frames=2.
1. Release reset → refresh high exactly in cycle 2; zero_buf=0; rd_c=32 for any address; frame_valid=0; busy=1.
2. Drive 8 writes 'A'..'H' in raster order starting the cycle after refresh → busy=0 after the (3,1) write. Then 2 vsyncs → front_bank=1 and frame_valid=1 on the second. Reading (2,1) returns 'G' one cycle later.
3. Issue writes with wr_en=1 during WAIT, and in the refresh cycle → front contents are unchanged after the next swap.
4. Pulse clear during FILL, complete the frame, swap → the following fill has zero_buf=1. After 8 writes of 32 and the next swap, every read returns 32 and zero_buf=0.
5. Make the last write and a vsync coincide with hold already saturated → no swap that edge; the swap occurs on the next vsync.
6. Deassert reset_n asynchronously mid-fill, in the middle of a clock period → rd_c=32, front_bank=0 and frame_valid=0 immediately, without a clock edge; refresh is re-issued after release.
